// File: rtl/calc_pkg.sv
// Shared key codes, ALU select encodings and sequencer state type for the calculator front end.
package calc_pkg;

  localparam logic [4:0] KEY_ADD    = 5'h10;
  localparam logic [4:0] KEY_SUB    = 5'h11;
  localparam logic [4:0] KEY_AND    = 5'h12;
  localparam logic [4:0] KEY_XOR    = 5'h13;
  localparam logic [4:0] KEY_EQUALS = 5'h14;
  localparam logic [4:0] KEY_CLEAR  = 5'h15;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_ZERO = 3'b011;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EXEC    = 2'd2,
    DONE    = 2'd3
  } calc_state_e;

  function automatic logic [2:0] op_to_sel(input logic [4:0] code);
    case (code)
      KEY_SUB: op_to_sel = ALU_SUB;
      KEY_AND: op_to_sel = ALU_AND;
      KEY_XOR: op_to_sel = ALU_XOR;
      default: op_to_sel = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/calc_operand_entry.sv
// Hex operand entry: nibble shift register with saturating digit counter, parallel load and clear.
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 3,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [3:0]       nibble,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CW-1:0]    load_cnt,
  output logic [WIDTH-1:0] value,
  output logic             empty
);

  localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

  logic [WIDTH-1:0] value_q, value_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    value_d = value_q;
    cnt_d   = cnt_q;
    if (clr) begin
      value_d = '0;
      cnt_d   = '0;
    end else if (load_en) begin
      value_d = load_val;
      cnt_d   = load_cnt;
    end else if (shift_en && (cnt_q < MAX_CNT)) begin
      // Once full, extra digits are swallowed without touching the operand.
      value_d = {value_q[WIDTH-5:0], nibble};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign value = value_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad-to-ALU sequencer: builds A, op, B from key events and latches the ALU result.
// Optional signed-overflow flag enabled by defining CALC_OVERFLOW_EN.
//
// state   | meaning
// ENTER_A | collecting operand A digits
// ENTER_B | operator latched, collecting operand B digits
// EXEC    | one cycle: ALU inputs stable, result captured at end
// DONE    | result held for display, chaining / repeat-equals allowed
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [4:0]       key_code,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] disp_value,
  output logic             result_valid,
  output logic             ovf
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DIGITS);

  calc_state_e      state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             a_clr, a_shift, a_load, b_clr, b_shift;
  logic [WIDTH-1:0] a_load_val, a_val, b_val;
  logic [CW-1:0]    a_load_cnt;
  logic             a_empty_unused, b_empty;

  logic accept, is_digit, is_op, is_eq, is_clr;
  logic [3:0] nib;

  assign accept   = key_valid && key_ready;
  assign is_digit = ~key_code[4];
  assign is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_XOR);
  assign is_eq    = (key_code == KEY_EQUALS);
  assign is_clr   = (key_code == KEY_CLEAR);
  assign nib      = key_code[3:0];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    result_d   = result_q;
    a_clr      = 1'b0;
    a_shift    = 1'b0;
    a_load     = 1'b0;
    a_load_val = '0;
    a_load_cnt = '0;
    b_clr      = 1'b0;
    b_shift    = 1'b0;
    if (state_q == EXEC) begin
      result_d = alu_y;
      state_d  = DONE;
    end else if (accept) begin
      if (is_clr) begin
        state_d  = ENTER_A;
        op_d     = ALU_ADD;
        result_d = '0;
        a_clr    = 1'b1;
        b_clr    = 1'b1;
      end else begin
        case (state_q)
          ENTER_A: begin
            if (is_digit) begin
              a_shift = 1'b1;
            end else if (is_op) begin
              op_d    = op_to_sel(key_code);
              b_clr   = 1'b1;
              state_d = ENTER_B;
            end
          end
          ENTER_B: begin
            if (is_digit) begin
              b_shift = 1'b1;
            end else if (is_op && b_empty) begin
              op_d = op_to_sel(key_code);
            end else if (is_eq) begin
              b_clr   = b_empty;
              state_d = EXEC;
            end
          end
          DONE: begin
            if (is_op) begin
              a_load     = 1'b1;
              a_load_val = result_q;
              a_load_cnt = FULL_CNT;
              op_d       = op_to_sel(key_code);
              b_clr      = 1'b1;
              state_d    = ENTER_B;
            end else if (is_digit) begin
              a_load     = 1'b1;
              a_load_val = {{(WIDTH-4){1'b0}}, nib};
              a_load_cnt = CW'(1);
              state_d    = ENTER_A;
            end else if (is_eq) begin
              // Repeat-equals: same op and B applied to the previous result.
              a_load     = 1'b1;
              a_load_val = result_q;
              a_load_cnt = FULL_CNT;
              state_d    = EXEC;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTER_A;
      op_q     <= ALU_ADD;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  calc_operand_entry #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CW(CW)) u_opnd_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (a_clr),
    .shift_en (a_shift),
    .nibble   (nib),
    .load_en  (a_load),
    .load_val (a_load_val),
    .load_cnt (a_load_cnt),
    .value    (a_val),
    .empty    (a_empty_unused)
  );

  calc_operand_entry #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CW(CW)) u_opnd_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (b_clr),
    .shift_en (b_shift),
    .nibble   (nib),
    .load_en  (1'b0),
    .load_val ('0),
    .load_cnt ('0),
    .value    (b_val),
    .empty    (b_empty)
  );

`ifdef CALC_OVERFLOW_EN
  logic ovf_q, ovf_d, ovf_calc;

  always_comb begin
    ovf_calc = 1'b0;
    if (op_q == ALU_ADD)
      ovf_calc = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (alu_y[WIDTH-1] != a_val[WIDTH-1]);
    else if (op_q == ALU_SUB)
      ovf_calc = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (alu_y[WIDTH-1] != a_val[WIDTH-1]);
    ovf_d = 1'b0;
    if (state_q == EXEC)
      ovf_d = ovf_calc;
    else if ((state_q == DONE) && (state_d == DONE))
      ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    case (state_q)
      ENTER_A: disp_value = a_val;
      DONE:    disp_value = result_q;
      default: disp_value = b_val;
    endcase
  end

  assign key_ready    = (state_q != EXEC);
  assign result_valid = (state_q == DONE);
  assign alu_a        = a_val;
  assign alu_b        = b_val;
  assign alu_s        = op_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer: key-vector table, result scoreboard, and
// hand-written sequences for reset during EXEC and a key held across EXEC.
module tb_calc_key_sequencer;
  import calc_pkg::*;

  localparam int WIDTH = 12;
`ifdef CALC_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_valid = 1'b0;
  logic             key_ready;
  logic [4:0]       key_code = 5'h00;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y, disp_value;
  logic [2:0]       alu_s;
  logic             result_valid, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  key;
    logic [11:0] disp;
    logic        rv;
    logic        ovf;
    logic        exec;
    logic [2:0]  sel;
  } vec_t;

  vec_t vecs[$];
  logic [11:0] sb_q[$];
  logic rv_prev = 1'b0;

  calc_key_sequencer #(.WIDTH(WIDTH), .DIGITS(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_code     (key_code),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_s        (alu_s),
    .alu_y        (alu_y),
    .disp_value   (disp_value),
    .result_valid (result_valid),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  // Combinational ALU model standing in for the real datapath.
  always_comb begin
    case (alu_s[1:0])
      2'b00:   alu_y = alu_s[2] ? (alu_a - alu_b) : (alu_a + alu_b);
      2'b01:   alu_y = alu_a & alu_b;
      2'b10:   alu_y = alu_a ^ alu_b;
      default: alu_y = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", disp_value);
      end else begin
        chk("sb_result", {20'h0, disp_value}, {20'h0, sb_q.pop_front()});
      end
    end
    rv_prev = result_valid;
  end

  task automatic add(input logic [4:0] key, input logic [11:0] disp, input logic rv,
                     input logic ov, input logic ex, input logic [2:0] sel);
    vec_t v;
    v.key = key; v.disp = disp; v.rv = rv; v.ovf = ov; v.exec = ex; v.sel = sel;
    vecs.push_back(v);
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the sequencer settles.
  task automatic send_key(input logic [4:0] code, output logic saw_exec, output logic [2:0] exec_sel);
    int n;
    saw_exec = 1'b0;
    exec_sel = 3'b000;
    key_code  = code;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!key_ready) chk("key_ready_timeout", 32'(key_ready), 32'd1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    if (!key_ready) begin
      saw_exec = 1'b1;
      exec_sel = alu_s;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic ex;
    logic [2:0] sel;

    add(5'h01, 12'h001, 0, 0, 0, ALU_ADD);
    add(5'h02, 12'h012, 0, 0, 0, ALU_ADD);
    add(5'h03, 12'h123, 0, 0, 0, ALU_ADD);
    add(KEY_ADD, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h00, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h00, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h05, 12'h005, 0, 0, 0, ALU_ADD);
    add(KEY_EQUALS, 12'h128, 1, 0, 1, ALU_ADD);
    add(KEY_SUB, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h08, 12'h008, 0, 0, 0, ALU_ADD);
    add(KEY_EQUALS, 12'h120, 1, 0, 1, ALU_SUB);
    add(KEY_EQUALS, 12'h118, 1, 0, 1, ALU_SUB);
    add(KEY_CLEAR, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h05, 12'h005, 0, 0, 0, ALU_ADD);
    add(KEY_SUB, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h07, 12'h007, 0, 0, 0, ALU_ADD);
    add(KEY_EQUALS, 12'hFFE, 1, 0, 1, ALU_SUB);
    add(5'h01, 12'h001, 0, 0, 0, ALU_ADD);
    add(5'h02, 12'h012, 0, 0, 0, ALU_ADD);
    add(5'h03, 12'h123, 0, 0, 0, ALU_ADD);
    add(5'h04, 12'h123, 0, 0, 0, ALU_ADD);
    add(KEY_CLEAR, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h07, 12'h007, 0, 0, 0, ALU_ADD);
    add(5'h0F, 12'h07F, 0, 0, 0, ALU_ADD);
    add(5'h0F, 12'h7FF, 0, 0, 0, ALU_ADD);
    add(KEY_ADD, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h01, 12'h001, 0, 0, 0, ALU_ADD);
    add(KEY_EQUALS, 12'h800, 1, 1, 1, ALU_ADD);
    add(KEY_AND, 12'h000, 0, 0, 0, ALU_ADD);
    add(KEY_XOR, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h0C, 12'h00C, 0, 0, 0, ALU_ADD);
    add(KEY_ADD, 12'h00C, 0, 0, 0, ALU_ADD);
    add(KEY_EQUALS, 12'h80C, 1, 0, 1, ALU_XOR);
    add(KEY_EQUALS, 12'h800, 1, 0, 1, ALU_XOR);
    add(KEY_CLEAR, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h0F, 12'h00F, 0, 0, 0, ALU_ADD);
    add(5'h0F, 12'h0FF, 0, 0, 0, ALU_ADD);
    add(5'h1F, 12'h0FF, 0, 0, 0, ALU_ADD);
    add(KEY_EQUALS, 12'h0FF, 0, 0, 0, ALU_ADD);
    add(KEY_AND, 12'h000, 0, 0, 0, ALU_ADD);
    add(5'h03, 12'h003, 0, 0, 0, ALU_ADD);
    add(5'h0C, 12'h03C, 0, 0, 0, ALU_ADD);
    add(KEY_EQUALS, 12'h03C, 1, 0, 1, ALU_AND);
    add(KEY_SUB, 12'h000, 0, 0, 0, ALU_ADD);
    add(KEY_EQUALS, 12'h03C, 1, 0, 1, ALU_SUB);

    // Reset values
    #12;
    chk("rst_key_ready", 32'(key_ready), 32'd1);
    chk("rst_disp", 32'(disp_value), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_alu_s", 32'(alu_s), 32'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].exec) sb_q.push_back(vecs[i].disp);
      send_key(vecs[i].key, ex, sel);
      chk($sformatf("v%0d_exec", i), 32'(ex), 32'(vecs[i].exec));
      if (vecs[i].exec) chk($sformatf("v%0d_alu_s", i), 32'(sel), 32'(vecs[i].sel));
      chk($sformatf("v%0d_disp", i), 32'(disp_value), 32'(vecs[i].disp));
      chk($sformatf("v%0d_rv", i), 32'(result_valid), 32'(vecs[i].rv));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf & OVF_ON));
      chk($sformatf("v%0d_ready", i), 32'(key_ready), 32'd1);
    end

    // Reset asserted during EXEC: result discarded, outputs back to reset values at once.
    send_key(KEY_CLEAR, ex, sel);
    send_key(5'h01, ex, sel);
    send_key(KEY_ADD, ex, sel);
    send_key(5'h02, ex, sel);
    key_code = KEY_EQUALS; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("mid_exec_ready", 32'(key_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_disp", 32'(disp_value), 32'd0);
    chk("mid_rst_rv", 32'(result_valid), 32'd0);
    chk("mid_rst_ready", 32'(key_ready), 32'd1);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rv", 32'(result_valid), 32'd0);
    send_key(5'h05, ex, sel);
    chk("post_rst_enter_a", 32'(disp_value), 32'h005);

    // Key held through EXEC: not taken in EXEC, taken in DONE.
    send_key(KEY_ADD, ex, sel);
    send_key(5'h03, ex, sel);
    sb_q.push_back(12'h008);
    key_code = KEY_EQUALS; key_valid = 1'b1;
    @(posedge clk); #1;
    key_code = KEY_CLEAR;
    chk("hold_exec_ready", 32'(key_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold_done_rv", 32'(result_valid), 32'd1);
    chk("hold_done_disp", 32'(disp_value), 32'h008);
    chk("hold_done_ready", 32'(key_ready), 32'd1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("hold_clear_rv", 32'(result_valid), 32'd0);
    chk("hold_clear_disp", 32'(disp_value), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
